// File: rtl/ysyx_22050710_dsram_responder.sv
// Data-side SRAM responder: accepts up to two outstanding requests and answers
// each one a fixed LAT cycles later, in order, with read data or an address error.
module ysyx_22050710_dsram_responder #(
    parameter int                 SRAM_DATA_WD = 64,
    parameter int                 ADDR_WD      = 32,
    parameter int                 MEM_WORDS    = 256,
    parameter logic [ADDR_WD-1:0] BASE_ADDR    = 32'h8000_0000,
    parameter int                 LAT          = 2
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_req,
    input  logic                      i_wr,
    input  logic [SRAM_DATA_WD/8-1:0] i_wstrb,
    input  logic [ADDR_WD-1:0]        i_addr,
    input  logic [SRAM_DATA_WD-1:0]   i_wdata,
    output logic                      o_addr_ok,
    output logic                      o_data_ok,
    output logic [SRAM_DATA_WD-1:0]   o_rdata,
    output logic                      o_err
);

    localparam int STRB_WD = SRAM_DATA_WD / 8;
    localparam int IDX_WD  = $clog2(MEM_WORDS);
    localparam logic [ADDR_WD:0] ADDR_END =
        {1'b0, BASE_ADDR} + (ADDR_WD + 1)'(8 * MEM_WORDS);

    logic [1:0]              outstanding;
    logic                    accept;
    logic                    in_range;
    logic [ADDR_WD-1:0]      offset;
    logic [IDX_WD-1:0]       idx;
    logic [SRAM_DATA_WD-1:0] mem [MEM_WORDS];
    logic [LAT-1:0]          pipe_valid;
    logic [LAT-1:0]          pipe_err;
    logic [SRAM_DATA_WD-1:0] pipe_data [LAT];

    // Accept is gated by reset so storage cannot be written while held in reset.
    assign o_addr_ok = (outstanding < 2'd2);
    assign accept    = i_req && o_addr_ok && i_rst_n;

    assign offset   = i_addr - BASE_ADDR;
    assign idx      = IDX_WD'(offset >> 3);
    assign in_range = ({1'b0, i_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, i_addr} < ADDR_END);

    // NOTE: sequential state uses non-blocking assignments so every stage
    // reads the pre-edge value of its neighbour and the shift is race-free.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pipe_valid  <= '0;
            pipe_err    <= '0;
            outstanding <= '0;
        end else begin
            pipe_valid[0] <= accept;
            pipe_err[0]   <= accept && !in_range;
            for (int i = LAT - 1; i > 0; i--) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_err[i]   <= pipe_err[i-1];
            end
            case ({accept, o_data_ok})
                2'b10:   outstanding <= outstanding + 2'd1;
                2'b01:   outstanding <= outstanding - 2'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // NOTE: storage and the data stages carry no reset; only the valid bits
    // need clearing, and resetting the array would prevent RAM inference.
    always_ff @(posedge i_clk) begin
        if (accept && i_wr && in_range) begin
            for (int b = 0; b < STRB_WD; b++) begin
                if (i_wstrb[b]) mem[idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
        pipe_data[0] <= (accept && !i_wr && in_range) ? mem[idx] : '0;
        for (int i = LAT - 1; i > 0; i--) begin
            pipe_data[i] <= pipe_data[i-1];
        end
    end

    assign o_data_ok = pipe_valid[LAT-1];
    assign o_err     = pipe_valid[LAT-1] && pipe_err[LAT-1];
    assign o_rdata   = o_data_ok ? pipe_data[LAT-1] : '0;

endmodule

// File: tb/tb_ysyx_22050710_dsram_responder.sv
// Directed bench for the data SRAM responder: a vector table for single
// transactions plus hand-written pipelining, reset and LAT=1 sequences.
module tb_ysyx_22050710_dsram_responder;

    typedef struct {
        logic        wr;
        logic [7:0]  strb;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic        exp_err;
        logic [63:0] exp_rdata;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        req, wr;
    logic [7:0]  wstrb;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic        addr_ok, data_ok, err;
    logic [63:0] rdata;

    logic        req1, wr1;
    logic [7:0]  wstrb1;
    logic [31:0] addr1;
    logic [63:0] wdata1;
    logic        addr_ok1, data_ok1, err1;
    logic [63:0] rdata1;

    int checks = 0;
    int errors = 0;

    vec_t        vecs [15];
    logic [31:0] b2b_addr [4];
    logic [63:0] b2b_data [4];
    logic        exp_ok [6];
    logic [63:0] expq [$];

    ysyx_22050710_dsram_responder #(.LAT(2)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_wr(wr), .i_wstrb(wstrb),
        .i_addr(addr), .i_wdata(wdata), .o_addr_ok(addr_ok), .o_data_ok(data_ok),
        .o_rdata(rdata), .o_err(err)
    );

    ysyx_22050710_dsram_responder #(.LAT(1)) u_dut_lat1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req1), .i_wr(wr1), .i_wstrb(wstrb1),
        .i_addr(addr1), .i_wdata(wdata1), .o_addr_ok(addr_ok1), .o_data_ok(data_ok1),
        .o_rdata(rdata1), .o_err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issues one request from an idle LAT=2 responder and checks its response.
    task automatic apply(input string name, input vec_t v);
        req   = 1'b1;
        wr    = v.wr;
        wstrb = v.strb;
        addr  = v.addr;
        wdata = v.wdata;
        @(negedge clk);
        check({name, "_addr_ok"}, 64'(addr_ok), 64'(1));
        @(posedge clk);
        #1;
        req   = 1'b0;
        wr    = 1'b0;
        wstrb = '0;
        @(negedge clk);
        check({name, "_early"}, 64'(data_ok), 64'(0));
        @(negedge clk);
        check({name, "_data_ok"}, 64'(data_ok), 64'(1));
        check({name, "_rdata"}, rdata, v.exp_rdata);
        check({name, "_err"}, 64'(err), 64'(v.exp_err));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int issued;
        int rsp;
        vec_t v;

        vecs[0]  = '{1'b1, 8'hFF, 32'h8000_0008, 64'h1122_3344_5566_7788, 1'b0, 64'h0};
        vecs[1]  = '{1'b0, 8'h00, 32'h8000_0008, 64'h0, 1'b0, 64'h1122_3344_5566_7788};
        vecs[2]  = '{1'b1, 8'h03, 32'h8000_0008, 64'h0000_0000_0000_AAAA, 1'b0, 64'h0};
        vecs[3]  = '{1'b0, 8'h00, 32'h8000_0008, 64'h0, 1'b0, 64'h1122_3344_5566_AAAA};
        vecs[4]  = '{1'b1, 8'hFF, 32'h8000_0000, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h0};
        vecs[5]  = '{1'b0, 8'h00, 32'h7FFF_FFF8, 64'h0, 1'b1, 64'h0};
        vecs[6]  = '{1'b0, 8'h00, 32'h8000_0800, 64'h0, 1'b1, 64'h0};
        vecs[7]  = '{1'b1, 8'hFF, 32'h8000_0800, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h0};
        vecs[8]  = '{1'b0, 8'h00, 32'h8000_0000, 64'h0, 1'b0, 64'h0123_4567_89AB_CDEF};
        vecs[9]  = '{1'b1, 8'h00, 32'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0};
        vecs[10] = '{1'b0, 8'h00, 32'h8000_0005, 64'h0, 1'b0, 64'h0123_4567_89AB_CDEF};
        vecs[11] = '{1'b1, 8'h3C, 32'h8000_0000, 64'h0000_CAFE_BABE_0000, 1'b0, 64'h0};
        vecs[12] = '{1'b0, 8'h00, 32'h8000_0000, 64'h0, 1'b0, 64'h0123_CAFE_BABE_CDEF};
        vecs[13] = '{1'b1, 8'hFF, 32'h8000_07F8, 64'hFEED_FACE_0123_4567, 1'b0, 64'h0};
        vecs[14] = '{1'b0, 8'h00, 32'h8000_07FF, 64'h0, 1'b0, 64'hFEED_FACE_0123_4567};

        b2b_addr = '{32'h8000_0000, 32'h8000_0008, 32'h8000_0000, 32'h8000_0008};
        b2b_data = '{64'h0123_CAFE_BABE_CDEF, 64'h1122_3344_5566_AAAA,
                     64'h0123_CAFE_BABE_CDEF, 64'h1122_3344_5566_AAAA};
        exp_ok   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        rst_n = 1'b0;
        req = 1'b0; wr = 1'b0; wstrb = '0; addr = '0; wdata = '0;
        req1 = 1'b0; wr1 = 1'b0; wstrb1 = '0; addr1 = '0; wdata1 = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_data_ok", 64'(data_ok), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_rdata", rdata, 64'h0);
        check("rst_addr_ok", 64'(addr_ok), 64'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single transactions
        for (int i = 0; i < 15; i++) begin
            apply($sformatf("vec%0d", i), vecs[i]);
        end

        // Four back-to-back reads with i_req held high
        issued = 0;
        rsp    = 0;
        for (int c = 0; c < 12; c++) begin
            if (issued < 4) begin
                req  = 1'b1;
                addr = b2b_addr[issued];
            end else begin
                req = 1'b0;
            end
            wr = 1'b0;
            @(negedge clk);
            if (c < 6) check($sformatf("b2b_addr_ok_c%0d", c), 64'(addr_ok), 64'(exp_ok[c]));
            if (data_ok) begin
                check($sformatf("b2b_rsp_le_acc_c%0d", c), 64'(rsp < issued), 64'(1));
                if (expq.size() > 0) check($sformatf("b2b_rdata_c%0d", c), rdata, expq.pop_front());
                check($sformatf("b2b_err_c%0d", c), 64'(err), 64'(0));
                rsp++;
            end
            if (req && addr_ok) begin
                expq.push_back(b2b_data[issued]);
                issued++;
            end
            @(posedge clk);
            #1;
        end
        req = 1'b0;
        check("b2b_accepts", 64'(issued), 64'(4));
        check("b2b_responses", 64'(rsp), 64'(4));

        // Reset one cycle after two accepts; a write attempted during reset must be dropped
        req = 1'b1; wr = 1'b0; addr = 32'h8000_0000;
        @(posedge clk);
        #1;
        addr = 32'h8000_0008;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        wr = 1'b1; wstrb = 8'hFF; wdata = 64'h0;
        @(negedge clk);
        check("midrst_data_ok", 64'(data_ok), 64'(0));
        check("midrst_addr_ok", 64'(addr_ok), 64'(1));
        check("midrst_err", 64'(err), 64'(0));
        check("midrst_rdata", rdata, 64'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("midrst_data_ok2", 64'(data_ok), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req = 1'b0; wr = 1'b0; wstrb = '0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("postrst_data_ok_c%0d", c), 64'(data_ok), 64'(0));
            check($sformatf("postrst_addr_ok_c%0d", c), 64'(addr_ok), 64'(1));
            @(posedge clk);
            #1;
        end
        v = '{1'b0, 8'h00, 32'h8000_0008, 64'h0, 1'b0, 64'h1122_3344_5566_AAAA};
        apply("postrst_read", v);

        // LAT=1: response and new accept in the same cycle keep the count steady
        for (int c = 0; c < 7; c++) begin
            if (c == 0) begin
                req1 = 1'b1; wr1 = 1'b1; wstrb1 = 8'hFF;
                addr1 = 32'h8000_0010; wdata1 = 64'h0000_0000_0000_5555;
            end else if (c <= 4) begin
                req1 = 1'b1; wr1 = 1'b0; wstrb1 = '0;
            end else begin
                req1 = 1'b0; wr1 = 1'b0;
            end
            @(negedge clk);
            if (c <= 4) check($sformatf("lat1_addr_ok_c%0d", c), 64'(addr_ok1), 64'(1));
            check($sformatf("lat1_data_ok_c%0d", c), 64'(data_ok1), 64'(c >= 1 && c <= 5));
            if (c >= 1 && c <= 5) begin
                check($sformatf("lat1_rdata_c%0d", c), rdata1,
                      (c == 1) ? 64'h0 : 64'h0000_0000_0000_5555);
                check($sformatf("lat1_err_c%0d", c), 64'(err1), 64'(0));
            end
            @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
